isqrt_seed_table_writer: RTL and testbench
==========================================

ISQRT_SEED_TABLE_WRITER -- requirements
Module: isqrt_seed_table_writer

Interface
REQ-001 SHALL have parameter LAST_USED_ADDR, default 2703: highest table address holding a computed seed; addresses above it are written 0.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to (re)fill the whole table; sampled every cycle.
REQ-005 SHALL have port busy  output  1  high while a fill is in progress.
REQ-006 SHALL have port done  output  1  high after a complete fill, held until the next accepted start.
REQ-007 SHALL have port we  output  1  single-cycle BRAM write strobe.
REQ-008 SHALL have port waddr  output  12  BRAM write address, valid when we=1.
REQ-009 SHALL have port wdata  output  32  seed word, Q8.24 unsigned, valid when we=1.

Function
REQ-010 SHALL use the FSM states IDLE, SETUP, SQUARE, COMPARE, WRITE, FINISH.
REQ-011 SHALL accept start only in IDLE or FINISH, entering SETUP with address counter 0, clearing done, and setting busy on the next cycle.
REQ-012 SHALL ignore start while busy=1.
REQ-013 SHALL visit every address 0..4095 in ascending order, each address taking exactly 64 cycles: 1 SETUP, 31 x (SQUARE, COMPARE), 1 WRITE.
REQ-014 SHALL, in SETUP, form the 32-bit unsigned operand x for address k as follows: k=1..15 -> x=1024+k; k=16..LAST_USED_ADDR -> p=10+(k-16)/128, m=(k-16) mod 128, x=2^p + m*2^(p-7) + 2^(p-8).
REQ-015 SHALL, for k=1..LAST_USED_ADDR, compute y=floor(2^36/sqrt(x)) by bit-serial bisection: y starts at 0; for bit b=30 down to 0, cand=y|2^b; SQUARE computes cand^2 (62 bits); COMPARE computes cand^2*x (94 bits) and sets y=cand if the product is <= 2^72.
REQ-016 SHALL force wdata=0x7FFFFFFF for address 0 and wdata=0 for addresses above LAST_USED_ADDR, while still spending 64 cycles on each.
REQ-017 SHALL assert we for exactly one cycle in WRITE, with waddr=k and wdata=y; address k is written on cycle 64*(k+1) after the accepting edge.
REQ-018 SHALL keep we=0 in every state other than WRITE.
REQ-019 SHALL, after writing address 4095, enter FINISH on the next cycle with busy=0 and done=1; total fill = 262144 cycles plus 1.
REQ-020 SHALL allow FINISH to accept start, restarting the fill from address 0 with done cleared.
REQ-021 SHALL compute all arithmetic unsigned, with no truncation before the 94-bit compare.

Reset
REQ-022 SHALL, when rst=1, go to IDLE on that edge with busy=0, done=0, we=0, waddr=0, wdata=0, address counter 0.
REQ-023 SHALL abort a fill in progress when rst is asserted: no further writes occur, the table is left partially written, and done stays 0 until a full fill completes.
REQ-024 SHALL give rst priority over start on the same edge.

Verification
REQ-025 SHALL be checked with this scenario: reset, then start pulse -> busy=1 next cycle; first we at cycle 64 with waddr=0, wdata=0x7FFFFFFF.
REQ-026 SHALL be checked with this scenario: full fill -> 4096 writes in ascending waddr, spaced 64 cycles apart, then done=1 and busy=0 one cycle after the last write.
REQ-027 SHALL be checked with this scenario: writes to waddr=1, 1808 and 2703 -> wdata equals a bench model of floor(2^36/sqrt(x)) for x=1025, 16842752 and 2^30+127*2^23+2^22; waddr=1808 gives approximately 0x00FF8060.
REQ-028 SHALL be checked with this scenario: writes to waddr=2704 and waddr=4095 -> wdata=0.
REQ-029 SHALL be checked with this scenario: start held high for the whole fill -> only a single fill occurs until FINISH, then an immediate restart with done dropping.
REQ-030 SHALL be checked with this scenario: rst asserted during the write slot of address 100 -> no write for address 100 or later, busy=0 and done=0 on the next cycle, and a subsequent start refills from address 0.

Source files
------------

// File: rtl/isqrt_seed_table_writer.sv
// Fills a 4096-entry BRAM with Q8.24 inverse-square-root seeds, one address every
// 64 cycles, using a bit-serial bisection of y = floor(2^36 / sqrt(x)).
module isqrt_seed_table_writer #(
  parameter int unsigned LAST_USED_ADDR = 2703
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        we,
  output logic [11:0] waddr,
  output logic [31:0] wdata
);

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned SQ_W   = 62;
  localparam int unsigned PROD_W = 94;

  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(LAST_USED_ADDR);
  localparam logic [ADDR_W-1:0] FINAL_A  = {ADDR_W{1'b1}};
  localparam logic [BIT_W-1:0]  TOP_BIT  = BIT_W'(30);
  localparam logic [PROD_W-1:0] LIMIT    = {21'd0, 1'b1, 72'd0};
  localparam logic [DATA_W-1:0] ADDR0_SEED = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SQUARE,
    COMPARE,
    WRITE,
    FINISH
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  addr, addr_nxt;
  logic [BIT_W-1:0]   bit_idx, bit_nxt;
  logic [DATA_W-1:0]  x, x_nxt;
  logic [DATA_W-1:0]  y, y_nxt;
  logic [SQ_W-1:0]    sq, sq_nxt;
  logic               busy_nxt, done_nxt, we_nxt;
  logic [ADDR_W-1:0]  waddr_nxt;
  logic [DATA_W-1:0]  wdata_nxt;

  logic [DATA_W-1:0]  cand;
  logic [PROD_W-1:0]  prod;
  logic               fits;
  logic [DATA_W-1:0]  y_fin;
  logic [ADDR_W-1:0]  rel;
  logic [5:0]         shamt;
  logic [DATA_W-1:0]  operand;

  // Operand for the current address: linear 1024+k below 16, else (257+2m) << (p-8)
  always_comb begin
    rel     = addr - ADDR_W'(16);
    shamt   = 6'(rel[11:7]) + 6'd2;
    operand = 32'd1;
    if (addr != '0 && addr < ADDR_W'(16)) begin
      operand = 32'd1024 + 32'(addr);
    end else if (addr >= ADDR_W'(16) && addr <= LAST_A) begin
      operand = {23'd0, 1'b1, rel[6:0], 1'b1} << shamt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      bit_idx <= '0;
      x       <= '0;
      y       <= '0;
      sq      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      bit_idx <= bit_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
      sq      <= sq_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      we      <= we_nxt;
      waddr   <= waddr_nxt;
      wdata   <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    bit_nxt   = bit_idx;
    x_nxt     = x;
    y_nxt     = y;
    sq_nxt    = sq;
    busy_nxt  = busy;
    done_nxt  = done;
    we_nxt    = 1'b0;
    waddr_nxt = waddr;
    wdata_nxt = wdata;

    cand  = y | (32'd1 << bit_idx);
    prod  = PROD_W'(sq) * PROD_W'(x);
    fits  = (prod <= LIMIT);
    y_fin = fits ? cand : y;

    case (state)
      IDLE, FINISH: begin
        if (start) begin
          state_nxt = SETUP;
          addr_nxt  = '0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
        end
      end
      SETUP: begin
        x_nxt     = operand;
        y_nxt     = '0;
        bit_nxt   = TOP_BIT;
        state_nxt = SQUARE;
      end
      SQUARE: begin
        sq_nxt    = SQ_W'(cand) * SQ_W'(cand);
        state_nxt = COMPARE;
      end
      COMPARE: begin
        y_nxt = y_fin;
        if (bit_idx == '0) begin
          state_nxt = WRITE;
          we_nxt    = 1'b1;
          waddr_nxt = addr;
          if (addr == '0) begin
            wdata_nxt = ADDR0_SEED;
          end else if (addr > LAST_A) begin
            wdata_nxt = '0;
          end else begin
            wdata_nxt = y_fin;
          end
        end else begin
          bit_nxt   = bit_idx - BIT_W'(1);
          state_nxt = SQUARE;
        end
      end
      WRITE: begin
        if (addr == FINAL_A) begin
          state_nxt = FINISH;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          addr_nxt  = addr + ADDR_W'(1);
          state_nxt = SETUP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_isqrt_seed_table_writer.sv
// Bench for isqrt_seed_table_writer: cycle-level reference of the fill schedule plus
// an independent floor(2^36/sqrt(x)) model, checked every cycle and at key points.
module tb_isqrt_seed_table_writer;

  localparam int LAST     = 2703;
  localparam int FILL_CYC = 64 * 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, we;
  logic [11:0] waddr;
  logic [31:0] wdata;

  int tests = 0;
  int fails = 0;

  isqrt_seed_table_writer dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .busy (busy),
    .done (done),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata)
  );

  always #5 clk = ~clk;

  // Largest y with y^2 * x <= 2^72, seeded from a real-valued estimate
  function automatic logic [31:0] isqrt_model(input logic [31:0] x);
    logic [127:0] lim, yy, xx;
    real xr, r;
    lim = 128'd1 << 72;
    xx  = 128'(x);
    xr  = x;
    r   = 68719476736.0 / $sqrt(xr);
    yy  = 128'(longint'(r));
    while ((yy + 1) * (yy + 1) * xx <= lim) yy = yy + 1;
    while (yy * yy * xx > lim) yy = yy - 1;
    return 32'(yy);
  endfunction

  function automatic logic [31:0] exp_seed(input int k);
    longint p, m, xv;
    if (k == 0) return 32'h7FFF_FFFF;
    if (k > LAST) return 32'd0;
    if (k < 16) return isqrt_model(32'(1024 + k));
    p  = 10 + (k - 16) / 128;
    m  = (k - 16) % 128;
    xv = (longint'(1) << p) + m * (longint'(1) << (p - 7)) + (longint'(1) << (p - 8));
    return isqrt_model(32'(xv));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference of the fill schedule: m_n counts cycles since the accepting edge
  bit m_fill = 1'b0;
  bit m_done = 1'b0;
  int m_n = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_fill = 1'b0; m_done = 1'b0; m_n = 0;
    end else if (!m_fill && start) begin
      m_fill = 1'b1; m_done = 1'b0; m_n = 1;
    end else if (m_fill) begin
      if (m_n == FILL_CYC) begin
        m_fill = 1'b0; m_done = 1'b1; m_n = 0;
      end else begin
        m_n++;
      end
    end
  end

  bit          checking = 1'b0;
  int          nw = 0;
  logic [31:0] cap [4096];
  bit          exp_we;
  int          exp_k;

  always @(negedge clk) begin
    if (checking) begin
      exp_we = m_fill && (m_n % 64 == 0);
      check("busy", 32'(busy), 32'(m_fill));
      check("done", 32'(done), 32'(m_done));
      check("we", 32'(we), 32'(exp_we));
      if (exp_we && we) begin
        exp_k = m_n / 64 - 1;
        check("waddr", 32'(waddr), 32'(exp_k));
        check("wdata", wdata, exp_seed(exp_k));
      end
      if (we === 1'b1) begin
        cap[waddr] = wdata;
        nw++;
      end
    end
  end

  initial begin
    int nw0;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", wdata, 32'd0);

    check("model_2p24", isqrt_model(32'h0100_0000), 32'h0100_0000);
    check("model_2p30", isqrt_model(32'h4000_0000), 32'h0020_0000);
    check("model_4096", isqrt_model(32'd4096), 32'h4000_0000);

    // start during reset must be ignored
    start = 1'b1;
    @(negedge clk);
    check("rst_over_start", 32'(busy), 32'd0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // start held high for the entire first fill
    start = 1'b1;
    nw = 0;
    for (int c = 1; c <= FILL_CYC + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("first_busy", 32'(busy), 32'd1);
        check("first_done", 32'(done), 32'd0);
      end
      if (c == 64) begin
        check("addr0_we", 32'(we), 32'd1);
        check("addr0_waddr", 32'(waddr), 32'd0);
        check("addr0_wdata", wdata, 32'h7FFF_FFFF);
      end
      if (c == FILL_CYC) begin
        check("last_we", 32'(we), 32'd1);
        check("last_waddr", 32'(waddr), 32'd4095);
        check("last_wdata", wdata, 32'd0);
      end
      if (c == FILL_CYC + 1) begin
        check("finish_busy", 32'(busy), 32'd0);
        check("finish_done", 32'(done), 32'd1);
        check("finish_we", 32'(we), 32'd0);
      end
    end

    check("write_count", 32'(nw), 32'd4096);
    check("seed_1", cap[1], isqrt_model(32'd1025));
    check("seed_1808", cap[1808], isqrt_model(32'd16842752));
    check("seed_2703", cap[2703], isqrt_model(32'h7FC0_0000));
    check("seed_2704", cap[2704], 32'd0);
    check("seed_4095", cap[4095], 32'd0);
    tests++;
    if (cap[1808] < 32'h00FF_805E || cap[1808] > 32'h00FF_8062) begin
      fails++;
      $display("FAIL seed_1808_approx: got %h expected about 00ff8060", cap[1808]);
    end

    // FINISH with start still high restarts immediately
    @(negedge clk);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    start = 1'b0;
    nw0 = nw;

    // reset lands on the edge that would open the write slot of address 100
    repeat (6462) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_we", 32'(we), 32'd0);
    check("abort_waddr", 32'(waddr), 32'd0);
    check("abort_writes", 32'(nw - nw0), 32'd100);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_no_writes", 32'(nw - nw0), 32'd100);

    // refill starts again from address 0
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("refill_busy", 32'(busy), 32'd1);
    repeat (63) @(negedge clk);
    check("refill_we", 32'(we), 32'd1);
    check("refill_waddr", 32'(waddr), 32'd0);
    check("refill_wdata", wdata, 32'h7FFF_FFFF);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
